// File: rtl/flash_op_sequencer.sv
// Whole-operation NAND sequencer: turns one controller op into a handshaked
// command/address byte stream, tWB wait, R/B wait with timeout and data-phase handoff.
module flash_op_sequencer #(
   parameter int unsigned ADDR_CYCLES = 5,
   parameter int unsigned TWB_CYCLES  = 10,
   parameter int unsigned TIMEOUT_W   = 20,
   parameter int unsigned TIMEOUT     = 1000000
) (
   input  logic        clock_100,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic        req_chip,
   input  logic [39:0] req_addr,
   output logic [7:0]  cmd,
   output logic [1:0]  cmd_type,
   output logic        cmd_valid,
   input  logic        cmd_ack,
   output logic [1:0]  ce_sel,
   input  logic        rb1_ctrl,
   input  logic        rb2_ctrl,
   output logic        data_go,
   output logic        data_rd,
   input  logic        data_done,
   output logic        busy,
   output logic        done,
   output logic [1:0]  status
);

   typedef enum logic [2:0] {
      IDLE, CMD1, ADDR, DATA, CMD2, TWB, WAIT_RB, DONE
   } state_t;

   typedef enum logic [1:0] {
      OP_RESET = 2'b00, OP_READ = 2'b01, OP_PROGRAM = 2'b10, OP_ERASE = 2'b11
   } op_t;

   localparam logic [2:0]           IDX_LAST  = 3'(ADDR_CYCLES - 1);
   localparam logic [2:0]           IDX_ERASE = 3'(ADDR_CYCLES - 3);
   localparam logic [TIMEOUT_W-1:0] TWB_LAST  = TIMEOUT_W'(TWB_CYCLES - 1);
   localparam logic [TIMEOUT_W-1:0] TO_LAST   = TIMEOUT_W'(TIMEOUT - 1);

   state_t               state, state_n;
   op_t                  op_q;
   logic                 chip_q;
   logic [39:0]          addr_q;
   logic [2:0]           idx, idx_n;
   logic [TIMEOUT_W-1:0] cnt, cnt_n;
   logic [1:0]           status_q, status_n;
   logic                 data_first;
   logic                 rb_sel;

   always_ff @(posedge clock_100) begin
      if (rst) begin
         state      <= IDLE;
         op_q       <= OP_RESET;
         chip_q     <= 1'b0;
         addr_q     <= '0;
         idx        <= '0;
         cnt        <= '0;
         status_q   <= 2'b00;
         data_first <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         cnt        <= cnt_n;
         status_q   <= status_n;
         data_first <= (state_n == DATA) && (state != DATA);
         if (state == IDLE && req_valid) begin
            op_q   <= op_t'(req_op);
            chip_q <= req_chip;
            addr_q <= req_addr;
         end
      end
   end

   always_comb begin
      state_n  = state;
      idx_n    = idx;
      cnt_n    = cnt;
      status_n = status_q;
      rb_sel   = chip_q ? rb2_ctrl : rb1_ctrl;
      case (state)
         IDLE: if (req_valid) begin
            state_n  = CMD1;
            status_n = 2'b00;
         end
         CMD1: if (cmd_ack) begin
            case (op_q)
               OP_RESET: begin
                  state_n = TWB;
                  cnt_n   = '0;
               end
               OP_ERASE: begin
                  state_n = ADDR;
                  idx_n   = IDX_ERASE;
               end
               default: begin
                  state_n = ADDR;
                  idx_n   = '0;
               end
            endcase
         end
         ADDR: if (cmd_ack) begin
            if (idx == IDX_LAST) state_n = (op_q == OP_PROGRAM) ? DATA : CMD2;
            else                 idx_n   = idx + 3'd1;
         end
         DATA: if (data_done) state_n = (op_q == OP_READ) ? DONE : CMD2;
         CMD2: if (cmd_ack) begin
            state_n = TWB;
            cnt_n   = '0;
         end
         TWB: begin
            if (cnt == TWB_LAST) begin
               state_n = WAIT_RB;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         // A timeout jumps straight to DONE, so a READ never reaches its data phase.
         WAIT_RB: begin
            if (rb_sel) begin
               state_n = (op_q == OP_READ) ? DATA : DONE;
            end else if (cnt == TO_LAST) begin
               state_n  = DONE;
               status_n = 2'b01;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      cmd       = 8'h00;
      cmd_type  = 2'b11;
      cmd_valid = 1'b0;
      case (state)
         CMD1: begin
            cmd_valid = 1'b1;
            cmd_type  = 2'b00;
            case (op_q)
               OP_RESET:   cmd = 8'hFF;
               OP_READ:    cmd = 8'h00;
               OP_PROGRAM: cmd = 8'h80;
               default:    cmd = 8'h60;
            endcase
         end
         ADDR: begin
            cmd_valid = 1'b1;
            cmd_type  = 2'b01;
            cmd       = 8'(addr_q >> {idx, 3'b000});
         end
         CMD2: begin
            cmd_valid = 1'b1;
            cmd_type  = 2'b00;
            case (op_q)
               OP_READ:    cmd = 8'h30;
               OP_PROGRAM: cmd = 8'h10;
               default:    cmd = 8'hD0;
            endcase
         end
         default: ;
      endcase
   end

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign ce_sel    = busy ? (chip_q ? 2'b10 : 2'b01) : 2'b00;
   assign done      = (state == DONE);
   assign status    = status_q;
   assign data_go   = (state == DATA) && data_first;
   assign data_rd   = (state == DATA) && (op_q == OP_READ);

endmodule

// File: tb/tb_flash_op_sequencer.sv
// Randomized bench for flash_op_sequencer: expected byte streams, data-phase and
// done timing are derived from the op rules and the R/B / data_done schedule driven here.
module tb_flash_op_sequencer;

   localparam int TO  = 100;
   localparam int BIG = 1 << 30;

   logic        clock_100 = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'b00;
   logic        req_chip = 1'b0;
   logic [39:0] req_addr = '0;
   logic [7:0]  cmd;
   logic [1:0]  cmd_type;
   logic        cmd_valid;
   logic        cmd_ack = 1'b0;
   logic [1:0]  ce_sel;
   logic        rb1_ctrl = 1'b0;
   logic        rb2_ctrl = 1'b0;
   logic        data_go;
   logic        data_rd;
   logic        data_done = 1'b0;
   logic        busy;
   logic        done;
   logic [1:0]  status;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   flash_op_sequencer #(
      .ADDR_CYCLES(5),
      .TWB_CYCLES (10),
      .TIMEOUT_W  (20),
      .TIMEOUT    (TO)
   ) dut (
      .clock_100(clock_100), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_chip(req_chip), .req_addr(req_addr),
      .cmd(cmd), .cmd_type(cmd_type), .cmd_valid(cmd_valid), .cmd_ack(cmd_ack),
      .ce_sel(ce_sel), .rb1_ctrl(rb1_ctrl), .rb2_ctrl(rb2_ctrl),
      .data_go(data_go), .data_rd(data_rd), .data_done(data_done),
      .busy(busy), .done(done), .status(status)
   );

   always #5 clock_100 = ~clock_100;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(negedge clock_100);
      cyc++;
   endtask

   task automatic check_idle(input logic [1:0] exp_status);
      check_eq("idle_req_ready", req_ready, 1'b1);
      check_eq("idle_busy", busy, 1'b0);
      check_eq("idle_ce_sel", ce_sel, 2'b00);
      check_eq("idle_done", done, 1'b0);
      check_eq("idle_cmd_valid", cmd_valid, 1'b0);
      check_eq("idle_status", status, exp_status);
   endtask

   // op: 0 RESET, 1 READ, 2 PROGRAM, 3 ERASE. ack_mode: 0 always, 1 every third cycle, 2 random.
   // rb_delay: cycles after accept before the selected die reports ready. rst_after: bytes
   // accepted before a reset is forced (-1 for none). Called at a negedge with the DUT idle.
   task automatic run_op(input int op, input int chip, input logic [39:0] addr,
                         input int ack_mode, input int rb_delay, input int dd_delay,
                         input int rst_after);
      int   c1[4] = '{'hFF, 'h00, 'h80, 'h60};
      int   c2[4] = '{'h00, 'h30, 'h10, 'hD0};
      int   exp_q[$];
      int   a, rb_at, w, c, nacc, ngo, exp_go_cnt;
      int   next_present, exp_go, exp_done, dd_at, n;
      logic [1:0] exp_status;
      logic [9:0] held_val, cur;
      logic held, fin, ack;

      exp_q.push_back(c1[op]);
      if (op != 0) begin
         for (int i = (op == 3) ? 2 : 0; i < 5; i++) exp_q.push_back((1 << 8) | int'(addr[8*i +: 8]));
         exp_q.push_back(c2[op]);
      end

      a            = cyc;
      rb_at        = (rb_delay >= BIG) ? BIG : a + rb_delay;
      nacc         = 0;
      ngo          = 0;
      exp_status   = 2'b00;
      exp_go_cnt   = (op == 1 || op == 2) ? 1 : 0;
      next_present = a + 1;
      exp_go       = -1;
      exp_done     = -1;
      dd_at        = -1;
      held         = 1'b0;
      held_val     = '0;
      fin          = 1'b0;
      n            = 0;

      check_eq("accept_ready", req_ready, 1'b1);
      req_valid = 1'b1;
      req_op    = 2'(op);
      req_chip  = 1'(chip);
      req_addr  = addr;

      while (!fin && n < 1000) begin
         step();
         n++;
         req_valid = 1'b0;
         check_eq("busy", busy, 1'b1);
         check_eq("ce_sel", ce_sel, (chip != 0) ? 2'b10 : 2'b01);
         cur = {cmd_type, cmd};
         if (cmd_valid) begin
            if (held) check_eq("hold_stable", cur, held_val);
            else      check_eq("present_cyc", cyc, next_present);
         end

         if (rst_after >= 0 && nacc == rst_after && cmd_valid) begin
            rst     = 1'b1;
            cmd_ack = 1'b0;
            step();
            check_eq("rst_cmd_valid", cmd_valid, 1'b0);
            check_eq("rst_cmd_type", cmd_type, 2'b11);
            check_eq("rst_ce_sel", ce_sel, 2'b00);
            check_eq("rst_busy", busy, 1'b0);
            check_eq("rst_req_ready", req_ready, 1'b1);
            check_eq("rst_done", done, 1'b0);
            rst = 1'b0;
            for (int k = 0; k < 5; k++) begin
               step();
               check_eq("rst_no_done", done, 1'b0);
            end
            return;
         end

         case (ack_mode)
            0:       ack = 1'b1;
            1:       ack = (cyc % 3 == 0);
            default: ack = 1'($urandom_range(0, 1));
         endcase
         cmd_ack = ack;

         if (cmd_valid) begin
            if (ack) begin
               held = 1'b0;
               nacc++;
               if (exp_q.size() == 0) begin
                  check_eq("extra_byte", cur, 10'h3FF);
               end else begin
                  check_eq("byte", cur, 10'(exp_q.pop_front()));
                  if (op == 2 && nacc == 6) begin
                     exp_go       = cyc + 1;
                     next_present = -1;
                  end else if (exp_q.size() != 0) begin
                     next_present = cyc + 1;
                  end else begin
                     next_present = -1;
                     w = cyc + 11;
                     c = (rb_at > w) ? rb_at : w;
                     if (c <= w + TO - 1) begin
                        if (op == 1) exp_go = c + 1;
                        else         exp_done = c + 1;
                     end else begin
                        exp_done   = w + TO;
                        exp_status = 2'b01;
                        if (op == 1) exp_go_cnt = 0;
                     end
                  end
               end
            end else begin
               held     = 1'b1;
               held_val = cur;
            end
         end

         if (data_go) begin
            ngo++;
            check_eq("go_cyc", cyc, exp_go);
            check_eq("data_rd", data_rd, (op == 1) ? 1'b1 : 1'b0);
            exp_go = -1;
            dd_at  = cyc + dd_delay;
         end
         data_done = (cyc == dd_at);
         if (cyc == dd_at) begin
            if (op == 1) exp_done = cyc + 1;
            else         next_present = cyc + 1;
         end

         if (chip == 0) begin
            rb1_ctrl = (cyc >= rb_at);
            rb2_ctrl = 1'($urandom_range(0, 1));
         end else begin
            rb2_ctrl = (cyc >= rb_at);
            rb1_ctrl = 1'($urandom_range(0, 1));
         end

         if (done) begin
            fin = 1'b1;
            check_eq("done_cyc", cyc, exp_done);
            check_eq("status", status, exp_status);
            check_eq("bytes_left", exp_q.size(), 0);
            check_eq("data_go_count", ngo, exp_go_cnt);
         end
      end

      check_eq("op_finished", fin, 1'b1);
      step();
      cmd_ack   = 1'b0;
      data_done = 1'b0;
      check_idle(exp_status);
   endtask

   initial begin
      rst = 1'b1;
      step();
      step();
      check_eq("rst_req_ready", req_ready, 1'b1);
      check_eq("rst_cmd", cmd, 8'h00);
      check_eq("rst_cmd_type", cmd_type, 2'b11);
      check_eq("rst_cmd_valid", cmd_valid, 1'b0);
      check_eq("rst_ce_sel", ce_sel, 2'b00);
      check_eq("rst_data_go", data_go, 1'b0);
      check_eq("rst_data_rd", data_rd, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_status", status, 2'b00);
      rst = 1'b0;
      step();

      run_op(0, 0, {8'($urandom), $urandom}, 0, 50, 0, -1);
      run_op(1, 1, 40'h0403020100, 0, 30, 3, -1);
      run_op(2, 0, {8'($urandom), $urandom}, 1, 40, 5, -1);
      run_op(3, 1, 40'hCCBBAA1122, 0, 20, 0, -1);
      run_op(1, 0, {8'($urandom), $urandom}, 2, BIG, 0, -1);
      run_op(2, 1, {8'($urandom), $urandom}, 0, BIG, 2, -1);
      run_op(0, 1, 40'h0, 0, BIG, 0, -1);
      run_op(1, 0, {8'($urandom), $urandom}, 0, 20, 0, 3);
      run_op(0, 0, 40'h0, 0, 15, 0, -1);

      for (int t = 0; t < 24; t++) begin
         run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                {8'($urandom), $urandom}, int'($urandom_range(0, 2)),
                ($urandom_range(0, 4) == 0) ? BIG : int'($urandom_range(0, 150)),
                int'($urandom_range(0, 4)), -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
